// File: rtl/laser_pulse_monitor_pkg.sv
// Shared constants and types for the laser-enable receive-side monitor.
// Holds the state encoding and the default on-time, which is the same value
// the laser timer uses.
package laser_pulse_monitor_pkg;

  // Default expected on-time in cycles, shared with the laser timer.
  localparam int unsigned LASER_ON_CYCLES = 3;

  // Pulse counter width and saturation value.
  localparam int unsigned PCNT_W   = 8;
  localparam logic [PCNT_W-1:0] PCNT_MAX = 8'hFF;

  // Monitor states.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_HIGH  = 2'd2,
    ST_STUCK = 2'd3
  } lpm_state_t;

endpackage : laser_pulse_monitor_pkg

// File: rtl/laser_pulse_monitor.sv
// Laser pulse monitor: measures each high pulse on the laser-enable line X
// and reports width and on-time match at the falling edge. It also flags a
// line stuck high.
//
// Ports:
//   Clk      - rising-edge clock
//   Rst      - asynchronous active-high reset
//   X        - monitored laser-enable line, synchronous to Clk
//   Clr      - synchronous clear of Stuck and PulseCnt
//   Done     - one-cycle strobe for a completed, valid-length pulse
//   Width    - measured high length, held between Done strobes
//   Ok       - Width == EXP_WIDTH, held between Done strobes
//   Stuck    - sticky stuck-high error
//   PulseCnt - completed pulse count, saturating at 255
module laser_pulse_monitor
  import laser_pulse_monitor_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = LASER_ON_CYCLES,
  parameter int unsigned CW        = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              X,
  input  logic              Clr,
  output logic              Done,
  output logic [CW-1:0]     Width,
  output logic              Ok,
  output logic              Stuck,
  output logic [PCNT_W-1:0] PulseCnt
);

  lpm_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_d;
  logic [CW-1:0]     width_d;
  logic              ok_d;
  logic              stuck_d;
  logic              stuck_set;
  logic [PCNT_W-1:0] pcnt_d;

  // State and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      Done     <= 1'b0;
      Width    <= '0;
      Ok       <= 1'b0;
      Stuck    <= 1'b0;
      PulseCnt <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      Done     <= done_d;
      Width    <= width_d;
      Ok       <= ok_d;
      Stuck    <= stuck_d;
      PulseCnt <= pcnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    width_d   = Width;
    ok_d      = Ok;
    pcnt_d    = PulseCnt;
    stuck_set = 1'b0;

    case (state_q)
      // A pulse already in progress at reset release is skipped.
      ST_WAIT: begin
        if (!X) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (X) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(1);
        end
      end
      ST_HIGH: begin
        if (X) begin
          if (cnt_q < CW'(TIMEOUT)) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d   = ST_STUCK;
            stuck_set = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          width_d = cnt_q;
          ok_d    = (cnt_q == CW'(EXP_WIDTH));
          if (PulseCnt != PCNT_MAX) pcnt_d = PulseCnt + PCNT_W'(1);
        end
      end
      ST_STUCK: begin
        if (!X) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT;
    endcase

    // Clr beats a completing pulse on PulseCnt; a new stuck error beats Clr.
    stuck_d = Stuck;
    if (Clr) begin
      stuck_d = 1'b0;
      pcnt_d  = '0;
    end
    if (stuck_set) stuck_d = 1'b1;
  end

endmodule : laser_pulse_monitor

// File: tb/tb_laser_pulse_monitor.sv
// Directed self-checking bench for laser_pulse_monitor (default parameters:
// EXP_WIDTH=3, CW=4, TIMEOUT=15).
module tb_laser_pulse_monitor;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       X   = 1'b0;
  logic       Clr = 1'b0;
  logic       Done;
  logic [3:0] Width;
  logic       Ok;
  logic       Stuck;
  logic [7:0] PulseCnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  laser_pulse_monitor dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .X        (X),
    .Clr      (Clr),
    .Done     (Done),
    .Width    (Width),
    .Ok       (Ok),
    .Stuck    (Stuck),
    .PulseCnt (PulseCnt)
  );

  always #5 Clk = ~Clk;

  // One rising edge, then settle before inputs change or outputs are read.
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Drive n high samples followed by one low sample.
  task automatic pulse(input int n);
    X = 1'b1;
    repeat (n) tick();
    X = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; X = 1'b0; Clr = 1'b0;
    repeat (3) tick();
    n_checks++; if (Done !== 1'b0)     $display("FAIL rst_done got %0b want 0", Done); else n_pass++;
    n_checks++; if (Width !== 4'd0)    $display("FAIL rst_width got %0d want 0", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b0)       $display("FAIL rst_ok got %0b want 0", Ok); else n_pass++;
    n_checks++; if (Stuck !== 1'b0)    $display("FAIL rst_stuck got %0b want 0", Stuck); else n_pass++;
    n_checks++; if (PulseCnt !== 8'd0) $display("FAIL rst_pcnt got %0d want 0", PulseCnt); else n_pass++;
    Rst = 1'b0;
    tick();                       // WAIT -> IDLE on low sample
    X = 1'b1;
    repeat (3) begin
      tick();
      n_checks++; if (Done !== 1'b0) $display("FAIL rst_early_done got %0b want 0", Done); else n_pass++;
    end
    X = 1'b0;
    tick();
    n_checks++; if (Done !== 1'b1)     $display("FAIL first_done got %0b want 1", Done); else n_pass++;
    n_checks++; if (Width !== 4'd3)    $display("FAIL first_width got %0d want 3", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b1)       $display("FAIL first_ok got %0b want 1", Ok); else n_pass++;
    n_checks++; if (PulseCnt !== 8'd1) $display("FAIL first_pcnt got %0d want 1", PulseCnt); else n_pass++;
    tick();
    n_checks++; if (Done !== 1'b0)     $display("FAIL done_one_cycle got %0b want 0", Done); else n_pass++;
  endtask

  task automatic test_wrong_width();
    Clr = 1'b1; tick(); Clr = 1'b0;
    n_checks++; if (PulseCnt !== 8'd0) $display("FAIL clr_pcnt got %0d want 0", PulseCnt); else n_pass++;
    pulse(2);
    n_checks++; if (Done !== 1'b1)  $display("FAIL w2_done got %0b want 1", Done); else n_pass++;
    n_checks++; if (Width !== 4'd2) $display("FAIL w2_width got %0d want 2", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b0)    $display("FAIL w2_ok got %0b want 0", Ok); else n_pass++;
    tick();
    pulse(1);
    n_checks++; if (Done !== 1'b1)     $display("FAIL w1_done got %0b want 1", Done); else n_pass++;
    n_checks++; if (Width !== 4'd1)    $display("FAIL w1_width got %0d want 1", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b0)       $display("FAIL w1_ok got %0b want 0", Ok); else n_pass++;
    n_checks++; if (PulseCnt !== 8'd2) $display("FAIL w1_pcnt got %0d want 2", PulseCnt); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int extra;
    t1 = -1; t2 = -1; extra = 0;
    pulse(3);
    if (Done === 1'b1) t1 = cyc;
    n_checks++; if (Width !== 4'd3) $display("FAIL b2b_w1 got %0d want 3", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b1)    $display("FAIL b2b_ok1 got %0b want 1", Ok); else n_pass++;
    X = 1'b1;
    repeat (3) begin
      tick();
      if (Done === 1'b1) extra++;
    end
    X = 1'b0;
    tick();
    if (Done === 1'b1) t2 = cyc;
    n_checks++; if (Width !== 4'd3) $display("FAIL b2b_w2 got %0d want 3", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b1)    $display("FAIL b2b_ok2 got %0b want 1", Ok); else n_pass++;
    n_checks++; if (extra !== 0)    $display("FAIL b2b_extra_done got %0d want 0", extra); else n_pass++;
    n_checks++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) != 4)
      $display("FAIL b2b_spacing got t1=%0d t2=%0d want both set and 4 apart", t1, t2);
    else n_pass++;
    tick();
  endtask

  task automatic test_stuck();
    int dones;
    dones = 0;
    // Width/Ok currently hold 3/1 from the last pulse.
    X = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (Done === 1'b1) dones++;
      if (k == 15) begin
        n_checks++; if (Stuck !== 1'b0) $display("FAIL stuck_at15 got %0b want 0", Stuck); else n_pass++;
      end
      if (k == 16) begin
        n_checks++; if (Stuck !== 1'b1) $display("FAIL stuck_at16 got %0b want 1", Stuck); else n_pass++;
      end
    end
    n_checks++; if (dones !== 0) $display("FAIL stuck_done got %0d want 0", dones); else n_pass++;
    X = 1'b0;
    tick();
    n_checks++; if (Done !== 1'b0)  $display("FAIL stuck_exit_done got %0b want 0", Done); else n_pass++;
    n_checks++; if (Width !== 4'd3) $display("FAIL stuck_exit_width got %0d want 3", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b1)    $display("FAIL stuck_exit_ok got %0b want 1", Ok); else n_pass++;
    n_checks++; if (Stuck !== 1'b1) $display("FAIL stuck_sticky got %0b want 1", Stuck); else n_pass++;
    Clr = 1'b1; tick(); Clr = 1'b0;
    n_checks++; if (Stuck !== 1'b0) $display("FAIL stuck_clr got %0b want 0", Stuck); else n_pass++;
    // Exactly TIMEOUT high samples is still a valid pulse.
    pulse(15);
    n_checks++; if (Done !== 1'b1)   $display("FAIL tmo_done got %0b want 1", Done); else n_pass++;
    n_checks++; if (Width !== 4'd15) $display("FAIL tmo_width got %0d want 15", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b0)     $display("FAIL tmo_ok got %0b want 0", Ok); else n_pass++;
    n_checks++; if (Stuck !== 1'b0)  $display("FAIL tmo_stuck got %0b want 0", Stuck); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    X = 1'b1;
    tick();
    tick();                       // second high sample
    #2 Rst = 1'b1;                // mid-cycle, asynchronous
    #1;
    n_checks++; if (Width !== 4'd0)    $display("FAIL midrst_width got %0d want 0", Width); else n_pass++;
    n_checks++; if (PulseCnt !== 8'd0) $display("FAIL midrst_pcnt got %0d want 0", PulseCnt); else n_pass++;
    n_checks++; if (Ok !== 1'b0)       $display("FAIL midrst_ok got %0b want 0", Ok); else n_pass++;
    tick();
    Rst = 1'b0;
    repeat (2) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    X = 1'b0;
    tick();
    if (Done === 1'b1) dones++;
    n_checks++; if (dones !== 0) $display("FAIL midrst_no_done got %0d want 0", dones); else n_pass++;
    pulse(3);
    n_checks++; if (Done !== 1'b1)  $display("FAIL midrst_done got %0b want 1", Done); else n_pass++;
    n_checks++; if (Width !== 4'd3) $display("FAIL midrst_width3 got %0d want 3", Width); else n_pass++;
    tick();
  endtask

  task automatic test_clr_sat();
    Clr = 1'b1; tick(); Clr = 1'b0;
    repeat (254) pulse(1);
    n_checks++; if (PulseCnt !== 8'd254) $display("FAIL sat_254 got %0d want 254", PulseCnt); else n_pass++;
    pulse(1);
    n_checks++; if (PulseCnt !== 8'd255) $display("FAIL sat_255 got %0d want 255", PulseCnt); else n_pass++;
    pulse(1);
    n_checks++; if (PulseCnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", PulseCnt); else n_pass++;
    // Clr on the same edge as a completing pulse.
    X = 1'b1;
    repeat (3) tick();
    X = 1'b0; Clr = 1'b1;
    tick();
    Clr = 1'b0;
    n_checks++; if (Done !== 1'b1)     $display("FAIL coll_done got %0b want 1", Done); else n_pass++;
    n_checks++; if (PulseCnt !== 8'd0) $display("FAIL coll_pcnt got %0d want 0", PulseCnt); else n_pass++;
    n_checks++; if (Width !== 4'd3)    $display("FAIL coll_width got %0d want 3", Width); else n_pass++;
    n_checks++; if (Ok !== 1'b1)       $display("FAIL coll_ok got %0b want 1", Ok); else n_pass++;
    // Clr on the same edge as stuck entry: the error wins.
    X = 1'b1;
    repeat (15) tick();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    n_checks++; if (Stuck !== 1'b1) $display("FAIL coll_stuck got %0b want 1", Stuck); else n_pass++;
    X = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_wrong_width();
    test_back_to_back();
    test_stuck();
    test_reset_mid();
    test_clr_sat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_laser_pulse_monitor
